prbs_ber_monitor: RTL and testbench

//  Bit-error-rate statistics stage directly downstream of the dataExtract aligner/PRBS7 checker on the GT RX path.

---
 rtl/prbs_mon_pkg.sv | 19 +
 rtl/popcount64.sv | 45 ++++
 rtl/prbs_ber_monitor.sv | 155 +++++++++++++++
 tb/tb_prbs_ber_monitor.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_mon_pkg.sv
// Shared types and helpers for the PRBS bit-error-rate monitor.
// State encoding is visible on debug and readout ports, so the values are fixed.
package prbs_mon_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_MEASURE  = 2'd2,
        ST_LOST     = 2'd3
    } mon_state_e;

    localparam int WORD_W_DEF = 64;

    // Width needed to hold a popcount of w bits (0..w inclusive).
    function automatic int pc_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/popcount64.sv
// Two-stage registered popcount: per-byte counts, then a sum of the byte counts.
// Defaults to 64 bits in / 7 bits out; width must be a multiple of 8.
module popcount64
    import prbs_mon_pkg::*;
#(
    parameter int W  = 64,
    parameter int CW = pc_width(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  i_bits,
    output logic [CW-1:0] o_count
);

    localparam int NG = W / 8;

    logic [3:0]    r_grp [NG];
    logic [CW-1:0] r_sum;
    logic [CW-1:0] w_sum;

    function automatic logic [3:0] byte_count(input logic [7:0] b);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c = c + 4'(b[i]);
        return c;
    endfunction

    always_comb begin
        w_sum = '0;
        for (int g = 0; g < NG; g++) w_sum = w_sum + CW'(r_grp[g]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < NG; g++) r_grp[g] <= '0;
            r_sum <= '0;
        end else begin
            for (int g = 0; g < NG; g++) r_grp[g] <= byte_count(i_bits[g*8 +: 8]);
            r_sum <= w_sum;
        end
    end

    assign o_count = r_sum;

endmodule

// File: rtl/prbs_ber_monitor.sv
// BER statistics behind the PRBS7 checker: lock qualification, windowed and total
// error counts, lock-loss detection. Words reach the FSM three edges after input.
module prbs_ber_monitor
    import prbs_mon_pkg::*;
#(
    parameter int WORD_W       = WORD_W_DEF,
    parameter int SETTLE_WORDS = 256,
    parameter int WINDOW_WORDS = 65536,
    parameter int LOSS_THRESH  = 64,
    parameter int TOT_W        = 48
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              aligned,
    input  logic [WORD_W-1:0] errorBits,
    input  logic              clear,
    output logic [1:0]        state,
    output logic [31:0]       win_err_count,
    output logic              win_valid,
    output logic [TOT_W-1:0]  tot_bit_count,
    output logic [TOT_W-1:0]  tot_err_count,
    output logic [15:0]       lock_loss_count
);

    localparam int CW  = pc_width(WORD_W);
    localparam int SCW = $clog2(SETTLE_WORDS + 1);
    localparam int WCW = (WINDOW_WORDS > 1) ? $clog2(WINDOW_WORDS) : 1;

    logic            r_aln_d1;
    logic            r_aln_p;
    logic [CW-1:0]   w_pc;
    mon_state_e      r_state;
    logic [SCW-1:0]  r_settle_cnt;
    logic [WCW-1:0]  r_win_cnt;
    logic [31:0]     r_acc;
    logic [31:0]     w_acc_next;
    logic            w_win_end;
    logic [31:0]     r_win_err;
    logic            r_win_valid;
    logic [TOT_W-1:0] r_tot_bit;
    logic [TOT_W-1:0] r_tot_err;
    logic [15:0]     r_lle;
    logic [15:0]     w_lle_inc;

    popcount64 #(.W(WORD_W), .CW(CW)) u_popcount (
        .clk     (clk),
        .rst     (reset),
        .i_bits  (errorBits),
        .o_count (w_pc)
    );

    // aligned follows the popcount pipeline so both describe the same word; clear does not flush it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_aln_d1 <= 1'b0;
            r_aln_p  <= 1'b0;
        end else begin
            r_aln_d1 <= aligned;
            r_aln_p  <= r_aln_d1;
        end
    end

    function automatic logic [TOT_W-1:0] sat_add(input logic [TOT_W-1:0] a,
                                                 input logic [TOT_W-1:0] b);
        logic [TOT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[TOT_W] ? '1 : s[TOT_W-1:0];
    endfunction

    assign w_acc_next = r_acc + 32'(w_pc);
    assign w_win_end  = (r_win_cnt == WCW'(WINDOW_WORDS - 1));
    assign w_lle_inc  = (r_lle == 16'hFFFF) ? r_lle : r_lle + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_UNLOCKED;
            r_settle_cnt <= '0;
            r_win_cnt    <= '0;
            r_acc        <= '0;
            r_win_err    <= '0;
            r_win_valid  <= 1'b0;
            r_tot_bit    <= '0;
            r_tot_err    <= '0;
            r_lle        <= '0;
        end else begin
            r_win_valid <= 1'b0;
            if (clear) begin
                r_state      <= ST_UNLOCKED;
                r_settle_cnt <= '0;
                r_win_cnt    <= '0;
                r_acc        <= '0;
                r_win_err    <= '0;
                r_tot_bit    <= '0;
                r_tot_err    <= '0;
                r_lle        <= '0;
            end else begin
                case (r_state)
                    ST_UNLOCKED: begin
                        if (r_aln_p) begin
                            r_state      <= ST_SETTLE;
                            r_settle_cnt <= SCW'(1);
                        end
                    end
                    ST_SETTLE: begin
                        if (!r_aln_p) begin
                            r_state <= ST_UNLOCKED;
                        end else if (r_settle_cnt == SCW'(SETTLE_WORDS)) begin
                            r_state   <= ST_MEASURE;
                            r_win_cnt <= '0;
                            r_acc     <= '0;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + SCW'(1);
                        end
                    end
                    ST_MEASURE: begin
                        if (!r_aln_p) begin
                            r_state   <= ST_UNLOCKED;
                            r_lle     <= w_lle_inc;
                            r_win_cnt <= '0;
                            r_acc     <= '0;
                        end else begin
                            r_tot_err <= sat_add(r_tot_err, TOT_W'(w_pc));
                            r_tot_bit <= sat_add(r_tot_bit, TOT_W'(WORD_W));
                            if (w_win_end) begin
                                r_win_err   <= w_acc_next;
                                r_win_valid <= 1'b1;
                                r_win_cnt   <= '0;
                                r_acc       <= '0;
                                if (w_acc_next > 32'(LOSS_THRESH)) begin
                                    r_state <= ST_LOST;
                                    r_lle   <= w_lle_inc;
                                end
                            end else begin
                                r_acc     <= w_acc_next;
                                r_win_cnt <= r_win_cnt + WCW'(1);
                            end
                        end
                    end
                    ST_LOST: begin
                        if (!r_aln_p) r_state <= ST_UNLOCKED;
                    end
                    default: r_state <= ST_UNLOCKED;
                endcase
            end
        end
    end

    assign state           = r_state;
    assign win_err_count   = r_win_err;
    assign win_valid       = r_win_valid;
    assign tot_bit_count   = r_tot_bit;
    assign tot_err_count   = r_tot_err;
    assign lock_loss_count = r_lle;

endmodule

// File: tb/tb_prbs_ber_monitor.sv
// Bench for prbs_ber_monitor: directed table, corner sequences and random traffic,
// all checked against a word-index based reference model.
module tb_prbs_ber_monitor;

    localparam int S  = 8;
    localparam int WW = 16;
    localparam int T  = 64;
    localparam int TW = 10;
    localparam longint TMAX = (64'd1 << TW) - 1;

    logic          clk;
    logic          reset;
    logic          aligned;
    logic [63:0]   errorBits;
    logic          clear;
    logic [1:0]    state;
    logic [31:0]   win_err_count;
    logic          win_valid;
    logic [TW-1:0] tot_bit_count;
    logic [TW-1:0] tot_err_count;
    logic [15:0]   lock_loss_count;

    prbs_ber_monitor #(
        .WORD_W(64), .SETTLE_WORDS(S), .WINDOW_WORDS(WW), .LOSS_THRESH(T), .TOT_W(TW)
    ) dut (
        .clk(clk), .reset(reset), .aligned(aligned), .errorBits(errorBits), .clear(clear),
        .state(state), .win_err_count(win_err_count), .win_valid(win_valid),
        .tot_bit_count(tot_bit_count), .tot_err_count(tot_err_count),
        .lock_loss_count(lock_loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: words are tracked by their index within the current aligned run.
    typedef struct { bit a; int pc; } word_t;
    word_t  q[$];
    int     m_k;
    bit     m_lost;
    longint m_acc, m_win, m_tbit, m_terr, m_lle;
    bit     m_valid;
    int     m_state;

    task automatic model_reset();
        q.delete();
        q.push_back('{1'b0, 0});
        q.push_back('{1'b0, 0});
        m_k = 0; m_lost = 0; m_acc = 0; m_win = 0;
        m_tbit = 0; m_terr = 0; m_lle = 0; m_valid = 0; m_state = 0;
    endtask

    task automatic model_edge(input bit a, input logic [63:0] e, input bit c);
        word_t w;
        w = q.pop_front();
        q.push_back('{a, $countones(e)});
        m_valid = 0;
        if (c) begin
            m_k = 0; m_lost = 0; m_acc = 0; m_win = 0;
            m_tbit = 0; m_terr = 0; m_lle = 0;
        end else if (!w.a) begin
            if (!m_lost && m_k > S && m_lle < 65535) m_lle++;
            m_k = 0; m_lost = 0; m_acc = 0;
        end else begin
            m_k++;
            if (!m_lost && m_k > S + 1) begin
                m_acc  += w.pc;
                m_terr = (m_terr + w.pc > TMAX) ? TMAX : m_terr + w.pc;
                m_tbit = (m_tbit + 64 > TMAX) ? TMAX : m_tbit + 64;
                if ((m_k - S - 1) % WW == 0) begin
                    m_win   = m_acc;
                    m_valid = 1;
                    if (m_acc > T) begin
                        m_lost = 1;
                        if (m_lle < 65535) m_lle++;
                    end
                    m_acc = 0;
                end
            end
        end
        m_state = (m_k == 0) ? 0 : m_lost ? 3 : (m_k <= S) ? 1 : 2;
    endtask

    function automatic bit next_is_window_end();
        return q[0].a && !m_lost && m_k >= S + 1 && ((m_k - S) % WW == 0);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("state", 64'(state), 64'(m_state));
        chk("win_valid", 64'(win_valid), 64'(m_valid));
        chk("win_err", 64'(win_err_count), 64'(m_win));
        chk("tot_bit", 64'(tot_bit_count), 64'(m_tbit));
        chk("tot_err", 64'(tot_err_count), 64'(m_terr));
        chk("lock_loss", 64'(lock_loss_count), 64'(m_lle));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_state"}, 64'(state), 64'd0);
        chk({tag, "_valid"}, 64'(win_valid), 64'd0);
        chk({tag, "_win"}, 64'(win_err_count), 64'd0);
        chk({tag, "_tbit"}, 64'(tot_bit_count), 64'd0);
        chk({tag, "_terr"}, 64'(tot_err_count), 64'd0);
        chk({tag, "_lle"}, 64'(lock_loss_count), 64'd0);
    endtask

    task automatic step(input bit a, input logic [63:0] e, input bit c);
        aligned = a; errorBits = e; clear = c;
        @(posedge clk);
        model_edge(a, e, c);
        #1;
        check_model();
    endtask

    typedef struct {
        bit a; logic [63:0] e; int n;
        int st; bit vld; int win; int terr; int lle;
    } vec_t;
    vec_t tbl[15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        // a, errorBits, cycles, state, win_valid, win_err, tot_err, lock_loss
        tbl[0]  = '{1'b1, 64'd1,    2, 0, 1'b0,   0,   0, 0};
        tbl[1]  = '{1'b1, 64'd1,    1, 1, 1'b0,   0,   0, 0};
        tbl[2]  = '{1'b1, 64'd1,    7, 1, 1'b0,   0,   0, 0};
        tbl[3]  = '{1'b1, 64'd1,    1, 2, 1'b0,   0,   0, 0};
        tbl[4]  = '{1'b1, 64'd1,   16, 2, 1'b1,  16,  16, 0};
        tbl[5]  = '{1'b1, 64'd1,   16, 2, 1'b1,  16,  32, 0};
        tbl[6]  = '{1'b1, 64'hFF,   2, 2, 1'b0,  16,  34, 0};
        tbl[7]  = '{1'b1, 64'hFF,  14, 3, 1'b1, 114, 146, 1};
        tbl[8]  = '{1'b1, 64'hFF,   4, 3, 1'b0, 114, 146, 1};
        tbl[9]  = '{1'b0, 64'd0,    3, 0, 1'b0, 114, 146, 1};
        tbl[10] = '{1'b1, 64'd0,    2, 0, 1'b0, 114, 146, 1};
        tbl[11] = '{1'b1, 64'd0,    9, 2, 1'b0, 114, 146, 1};
        tbl[12] = '{1'b1, 64'd0,    5, 2, 1'b0, 114, 146, 1};
        tbl[13] = '{1'b0, 64'd0,    2, 2, 1'b0, 114, 146, 1};
        tbl[14] = '{1'b0, 64'd0,    1, 0, 1'b0, 114, 146, 2};

        reset = 1'b1; aligned = 1'b0; errorBits = '0; clear = 1'b0;
        model_reset();
        #11;
        check_zero("reset");
        #1 reset = 1'b0;

        for (int r = 0; r < 15; r++) begin
            for (int i = 0; i < tbl[r].n; i++) step(tbl[r].a, tbl[r].e, 1'b0);
            chk($sformatf("tbl%0d_state", r), 64'(state), 64'(tbl[r].st));
            chk($sformatf("tbl%0d_valid", r), 64'(win_valid), 64'(tbl[r].vld));
            chk($sformatf("tbl%0d_win", r), 64'(win_err_count), 64'(tbl[r].win));
            chk($sformatf("tbl%0d_terr", r), 64'(tot_err_count), 64'(tbl[r].terr));
            chk($sformatf("tbl%0d_lle", r), 64'(lock_loss_count), 64'(tbl[r].lle));
        end

        // Saturation: a full window of all-ones words pushes tot_err past 1023.
        for (int i = 0; i < 2 + S + 1 + WW; i++) step(1'b1, '1, 1'b0);
        chk("sat_terr", 64'(tot_err_count), TMAX);
        chk("sat_tbit", 64'(tot_bit_count), TMAX);
        chk("sat_state", 64'(state), 64'd3);
        chk("sat_win", 64'(win_err_count), 64'd1024);
        chk("sat_lle", 64'(lock_loss_count), 64'd3);
        for (int i = 0; i < 4; i++) step(1'b1, '1, 1'b0);
        chk("sat_hold", 64'(tot_err_count), TMAX);

        step(1'b1, 64'd1, 1'b1);
        check_zero("clear");

        // Clear landing on the window-end edge suppresses win_valid.
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (next_is_window_end()) found = 1;
            else step(1'b1, 64'd1, 1'b0);
        end
        chk("wend_reached", 64'(found), 64'd1);
        step(1'b1, 64'd1, 1'b1);
        check_zero("wend_clear");

        // Async reset in the middle of MEASURE with live counters.
        for (int i = 0; i < 40; i++) step(1'b1, 64'h3, 1'b0);
        chk("pre_reset_state", 64'(state), 64'd2);
        #2 reset = 1'b1;
        #1;
        check_zero("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_hold_valid", 64'(win_valid), 64'd0);
        #3 reset = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            bit a, c;
            logic [63:0] e;
            int r;
            a = ($urandom_range(0, 149) != 0);
            c = ($urandom_range(0, 999) == 0);
            r = $urandom_range(0, 59);
            if (r < 36)      e = '0;
            else if (r < 59) e = 64'd1 << $urandom_range(0, 63);
            else             e = {$urandom, $urandom};
            step(a, e, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
